// File: rtl/sonar_scheduler_pkg.sv
// Shared types and constants for the sonar measurement sequencer.
// The defaults assume a 50 MHz system clock.
package sonar_scheduler_pkg;

  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    DISPARA  = 3'd1,
    AGUARDA  = 3'd2,
    REGISTRA = 3'd3,
    ABORTA   = 3'd4,
    ESPERA   = 3'd5
  } state_t;

  localparam logic [3:0] DB_OCIOSO   = 4'h0;
  localparam logic [3:0] DB_DISPARA  = 4'h1;
  localparam logic [3:0] DB_AGUARDA  = 4'h2;
  localparam logic [3:0] DB_REGISTRA = 4'h3;
  localparam logic [3:0] DB_ABORTA   = 4'h4;
  localparam logic [3:0] DB_ESPERA   = 4'h5;
  localparam logic [3:0] DB_ILEGAL   = 4'hE;

  localparam int unsigned DEF_MEAS_W  = 12;
  localparam int unsigned DEF_CNT_W   = 26;
  localparam int unsigned DEF_TIMEOUT = 2_500_000;
  localparam int unsigned DEF_GAP     = 3_000_000;
  localparam int unsigned DEF_PERIOD  = 25_000_000;

  function automatic logic [3:0] db_code(input state_t s);
    case (s)
      OCIOSO:   db_code = DB_OCIOSO;
      DISPARA:  db_code = DB_DISPARA;
      AGUARDA:  db_code = DB_AGUARDA;
      REGISTRA: db_code = DB_REGISTRA;
      ABORTA:   db_code = DB_ABORTA;
      ESPERA:   db_code = DB_ESPERA;
      default:  db_code = DB_ILEGAL;
    endcase
  endfunction

endpackage

// File: rtl/sonar_scheduler_if.sv
// Request/result bundle between the sequencer, its controlling logic and the
// HC-SR04 interface controller.
interface sonar_scheduler_if
  import sonar_scheduler_pkg::*;
#(
  parameter int unsigned MEAS_W = DEF_MEAS_W
);
  logic              modo;
  logic              medir;
  logic              pronto_if;
  logic [MEAS_W-1:0] medida_if;
  logic              medir_if;
  logic              reset_if;
  logic [MEAS_W-1:0] medida;
  logic              valido;
  logic              erro_timeout;
  logic              ocupado;
  logic [7:0]        n_medidas;
  logic [3:0]        db_estado;

  modport master (
    output modo, medir, pronto_if, medida_if,
    input  medir_if, reset_if, medida, valido, erro_timeout, ocupado,
           n_medidas, db_estado
  );

  modport slave (
    input  modo, medir, pronto_if, medida_if,
    output medir_if, reset_if, medida, valido, erro_timeout, ocupado,
           n_medidas, db_estado
  );
endinterface

// File: rtl/sonar_timer.sv
// Free-running cycle counter with synchronous clear that holds at LIMIT.
module sonar_timer #(
  parameter int unsigned CNT_W = 26,
  parameter int unsigned LIMIT = 24_999_999
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (r_count != LIM) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/sonar_scheduler.sv
// Measurement sequencer: manual/periodic triggering with minimum gap,
// per-measurement timeout watchdog, result latch and success counter.
module sonar_scheduler
  import sonar_scheduler_pkg::*;
#(
  parameter int unsigned MEAS_W         = DEF_MEAS_W,
  parameter int unsigned CNT_W          = DEF_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int unsigned GAP_CYCLES     = DEF_GAP,
  parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD
) (
  input  logic             clock,
  input  logic             reset,
  sonar_scheduler_if.slave bus
);
  localparam logic [CNT_W-1:0] T_TIMEOUT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_GAP     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_PERIOD  = CNT_W'(PERIOD_CYCLES - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_medir_d;
  logic              w_rise;
  logic              r_pending;
  logic              w_clr;
  logic [CNT_W-1:0]  w_t;
  logic [MEAS_W-1:0] r_medida;
  logic              r_erro;
  logic [7:0]        r_n;

  assign w_rise = bus.medir & ~r_medir_d;
  // Clearing on entry makes t read 0 during DISPARA, so trigger spacing is exactly GAP/PERIOD.
  assign w_clr  = (w_next == DISPARA);

  sonar_timer #(
    .CNT_W (CNT_W),
    .LIMIT (PERIOD_CYCLES - 1)
  ) u_timer (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_clr   (w_clr),
    .o_count (w_t)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= OCIOSO;
      r_medir_d <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_medir_d <= bus.medir;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      OCIOSO:   if (bus.modo || w_rise) w_next = DISPARA;
      DISPARA:  w_next = AGUARDA;
      AGUARDA: begin
        if (bus.pronto_if)       w_next = REGISTRA;
        else if (w_t == T_TIMEOUT) w_next = ABORTA;
      end
      REGISTRA: w_next = ESPERA;
      ABORTA:   w_next = ESPERA;
      ESPERA: begin
        if (bus.modo) begin
          if (w_t == T_PERIOD) w_next = DISPARA;
        end else if (w_t >= T_GAP) begin
          // A rise landing on the exit cycle is served directly rather than parked as pending.
          w_next = (r_pending || w_rise) ? DISPARA : OCIOSO;
        end
      end
      default:  w_next = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (r_state == OCIOSO) begin
      if (bus.modo) r_pending <= 1'b0;
    end else if (r_state == ESPERA && !bus.modo && w_next == DISPARA) begin
      r_pending <= 1'b0;
    end else if (w_rise) begin
      r_pending <= 1'b1;
    end
  end

  // Result is captured with pronto_if so it is already visible while valido is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_medida <= '0;
      r_erro   <= 1'b0;
      r_n      <= '0;
    end else if (r_state == AGUARDA) begin
      if (bus.pronto_if) begin
        r_medida <= bus.medida_if;
        r_n      <= r_n + 8'd1;
        r_erro   <= 1'b0;
      end else if (w_next == ABORTA) begin
        r_erro   <= 1'b1;
      end
    end
  end

  assign bus.medir_if     = (r_state == DISPARA);
  assign bus.reset_if     = (r_state == ABORTA);
  assign bus.valido       = (r_state == REGISTRA);
  assign bus.ocupado      = (r_state != OCIOSO);
  assign bus.db_estado    = db_code(r_state);
  assign bus.medida       = r_medida;
  assign bus.erro_timeout = r_erro;
  assign bus.n_medidas    = r_n;
endmodule

// File: doc/sonar_scheduler.md
Name: sonar_scheduler

Overview:
Measurement sequencer that sits in front of the HC-SR04 interface controller and decides when the interface measures. It accepts manual requests or runs periodic auto mode, and enforces a minimum trigger-to-trigger gap. It watchdogs each measurement with a timeout, latches valid results, counts successful measurements and flags timeouts.

Parameters:
MEAS_W, 12, width of measurement word from interface
CNT_W, 26, timer width; must hold PERIOD_CYCLES-1
TIMEOUT_CYCLES, 2_500_000, max cycles from trigger to pronto_if (50 ms @ 50 MHz)
GAP_CYCLES, 3_000_000, min cycles between consecutive triggers (60 ms)
PERIOD_CYCLES, 25_000_000, auto-mode trigger period (0.5 s); constraint TIMEOUT_CYCLES < GAP_CYCLES <= PERIOD_CYCLES

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; one clock domain
modo  in  1  1 = auto periodic, 0 = manual
medir  in  1  manual request; only rising edge acts
pronto_if  in  1  interface done pulse
medida_if  in  MEAS_W  interface result, valid with pronto_if
medir_if  out  1  1-cycle start pulse to interface
reset_if  out  1  1-cycle abort/reset pulse to interface
medida  out  MEAS_W  last valid result
valido  out  1  1-cycle pulse when medida updated
erro_timeout  out  1  sticky: last attempt timed out
ocupado  out  1  high in every state except OCIOSO
n_medidas  out  8  successful measurement count, wraps 255->0
db_estado  out  4  state code for debug display

Behaviour:
- Reset (async): state OCIOSO. All outputs 0, timer 0, pending 0, medir edge register 0.
- Edge detect: rise = medir & ~medir_d, where medir_d is registered.
- Timer t: cleared to 0 in DISPARA, otherwise +1 per cycle, saturating at PERIOD_CYCLES-1.
- Outputs are Moore.
- FSM (db_estado code):
  - OCIOSO (0): go to DISPARA if modo=1 or rise.
  - DISPARA (1): medir_if=1; t=0; next AGUARDA.
  - AGUARDA (2): if pronto_if -> REGISTRA; else if t==TIMEOUT_CYCLES-1 -> ABORTA.
  - REGISTRA (3): medida<=medida_if, valido=1, n_medidas+1, erro_timeout<=0; next ESPERA.
  - ABORTA (4): reset_if=1, erro_timeout<=1, medida unchanged; next ESPERA.
  - ESPERA (5): exit evaluated with modo sampled in this state:
    - modo=1 and t==PERIOD_CYCLES-1 -> DISPARA.
    - modo=0 and pending and t>=GAP_CYCLES-1 -> DISPARA, pending cleared.
    - modo=0 and no pending and t>=GAP_CYCLES-1 -> OCIOSO.
  - Illegal encodings: db_estado=E, next OCIOSO.
- Trigger spacing: exactly PERIOD_CYCLES in auto; exactly GAP_CYCLES for a pending manual request.
- Pending request: a rise in any state other than OCIOSO sets a 1-deep pending flag; further rises are dropped. Pending is cleared on entry to OCIOSO when modo=1 (auto supersedes it).
- pronto_if and timeout in the same cycle: pronto_if wins (REGISTRA, no reset_if).
- pronto_if outside AGUARDA: ignored.
- modo changing mid-measurement: the current measurement completes; only the ESPERA exit is affected.
- Reset mid-operation: immediate return to reset values; any partial measurement is discarded.

Decomposition:
- Shared package: state encodings, db_estado codes, default timing constants for 50 MHz.
- Sub-module sonar_timer: CNT_W counter with synchronous clear and saturation at a parameter limit.
- Edge detect and FSM stay in the top module.

Test Plan (MEAS_W=12, TIMEOUT=10, GAP=20, PERIOD=40):
1. Manual: modo=0, medir rises, pronto_if with medida_if=0x123 three cycles after medir_if -> one medir_if pulse; next cycle valido=1, medida=0x123, n_medidas=1; returns to OCIOSO at t=20.
2. Timeout: trigger, no pronto_if -> AGUARDA exits at t=9; reset_if pulse one cycle; erro_timeout=1; medida unchanged; a subsequent good measurement clears erro_timeout.
3. Auto: modo=1, pronto_if at t=3 each time -> medir_if pulses exactly 40 cycles apart; n_medidas counts 1,2,3.
4. Pending: second medir rise during AGUARDA -> second medir_if exactly 20 cycles after the first; a third rise during that window is dropped.
5. Race: pronto_if asserted at t=9 -> REGISTRA taken, no reset_if, erro_timeout stays 0.
6. Reset during AGUARDA -> all outputs 0 and db_estado=0 immediately; late pronto_if ignored; next medir rise works normally.
